serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor for the ALU datapath; computes `a - b` LSB-first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Trades latency for area against the parallel adder chain; it is the subtract-direction companion to the gate-level full adder.
- Operands are captured on a `start` handshake. The result and flags are registered, then `done` pulses for one cycle.

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB-first through one
// full-subtractor cell and a borrow flip-flop. Define SERIAL_SUB_OVF_EN to build ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bff;
  logic [CW-1:0]    cnt;

  logic             a0;
  logic             b0;
  logic             d;
  logic             bout;
  logic             last;
  logic [WIDTH-1:0] res_final;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    a0        = a_sr[0];
    b0        = b_sr[0];
    d         = a0 ^ b0 ^ bff;
    bout      = (~a0 & b0) | (~(a0 ^ b0) & bff);
    last      = (cnt == CW'(WIDTH - 1));
    res_final = {d, res_sr[WIDTH-1:1]};
  end

  // NOTE: every register below uses non-blocking assignment so all flops
  // sample pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both flags decode straight from the state register, so they are glitch-free
  // and have no path from any input.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // NOTE: the operand and partial-result registers are reset too, so an
  // aborted operation leaves nothing behind that a later one could observe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bff    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bff    <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_final;
          bff    <= bout;
          // Counter is wide enough to hold WIDTH, so this never wraps.
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Visible results update only on the RUN->DONE edge and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (state == RUN && last) begin
      diff   <= res_final;
      borrow <= bout;
      zero   <= (res_final == '0);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic [1:0] msb_q;

  // msb_q = {a[W-1], b[W-1]} of the captured operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_q <= 2'b00;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && start) msb_q <= {a[WIDTH-1], b[WIDTH-1]};
      // The last bit processed is the result MSB, so d is diff[W-1].
      if (state == RUN && last)   ovf   <= (msb_q[1] != msb_q[0]) && (d != msb_q[1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random traffic,
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed overflow from plain integer arithmetic.
  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVF_EN
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: an operation accepted in idle completes WIDTH edges later,
  // then the done pulse lasts one edge; results come from arithmetic.
  logic         m_busy, m_done, m_borrow, m_zero, m_ovf;
  logic [W-1:0] m_diff;
  logic         p_borrow, p_zero, p_ovf;
  logic [W-1:0] p_diff;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cnt <= 0;
      m_diff <= '0; m_borrow <= 0; m_zero <= 0; m_ovf <= 0;
      p_diff <= '0; p_borrow <= 0; p_zero <= 0; p_ovf <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == W - 1) begin
        m_busy   <= 0;
        m_done   <= 1;
        m_diff   <= p_diff;
        m_borrow <= p_borrow;
        m_zero   <= p_zero;
        m_ovf    <= p_ovf;
      end
    end else if (start) begin
      m_busy   <= 1;
      m_cnt    <= 0;
      p_diff   <= W'(a - b);
      p_borrow <= (a < b);
      p_zero   <= (a == b);
      p_ovf    <= ovf_of(a, b);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",   busy,   m_busy);
      check("done",   done,   m_done);
      check("diff",   diff,   m_diff);
      check("borrow", borrow, m_borrow);
      check("zero",   zero,   m_zero);
      check("ovf",    ovf,    m_ovf);
    end
  end

  // One directed operation with hand-computed expectations and latency check.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] prev_diff,
                        input logic [W-1:0] e_diff, input logic e_borrow,
                        input logic e_zero, input logic e_ovf);
    int n;
    bit seen;
    @(negedge clk);
    start = 1; a = ia; b = ib;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check("op_busy_after_accept", busy, 1);
    n = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      check("op_diff_held", diff, prev_diff);
    end
    check("op_done_seen", seen, 1);
    check("op_latency", n, W);
    check("op_busy_at_done", busy, 0);
    check("op_diff", diff, e_diff);
    check("op_borrow", borrow, e_borrow);
    check("op_zero", zero, e_zero);
    check("op_ovf", ovf, e_ovf);
    @(negedge clk);
    check("op_done_one_cycle", done, 0);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy && !done) begin
        idle = 1;
        break;
      end
    end
    check("wait_idle", idle, 1);
  endtask

  initial begin
    int ndone;
    logic exp_ovf80;
`ifdef SERIAL_SUB_OVF_EN
    exp_ovf80 = 1'b1;
`else
    exp_ovf80 = 1'b0;
`endif
    rst_n = 0; start = 0; a = '0; b = '0;
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    rst_n = 1;

    run_op(8'h05, 8'h03, 8'h00, 8'h02, 0, 0, 0);
    run_op(8'h03, 8'h05, 8'h02, 8'hFE, 1, 0, 0);
    run_op(8'h2A, 8'h2A, 8'hFE, 8'h00, 0, 1, 0);
    run_op(8'h80, 8'h01, 8'h00, 8'h7F, 0, 0, exp_ovf80);
    run_op(8'hFF, 8'h00, 8'h7F, 8'hFF, 0, 0, 0);
    run_op(8'h00, 8'hFF, 8'hFF, 8'h01, 1, 0, 0);

    // start held through RUN and DONE with operands changing mid-run.
    @(negedge clk);
    start = 1; a = 8'h40; b = 8'h11;
    @(posedge clk);
    ndone = 0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == 3) begin a = 8'h01; b = 8'h77; end
    end
    check("held_one_done", ndone, 1);
    check("held_diff", diff, 8'h2F);
    check("held_idle_at_e9", busy, 0);
    @(negedge clk);
    check("held_reaccept_e10", busy, 1);
    start = 0;
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1; a = 8'h33; b = 8'h22;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
    check("midrst_zero", zero, 0);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(8'h10, 8'h01, 8'h00, 8'h0F, 0, 0, 0);

    // Random traffic: random start requests, operands and boundary values.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       a = 8'h80;
        1:       a = 8'h7F;
        2:       a = 8'h00;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 8'hFF;
        1:       b = 8'h80;
        2:       b = a;
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    start = 0;
    wait_idle();
    @(negedge clk);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
